// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - four-source interrupt front-end with IO-mapped STATUS/MASK/MODE/SWTRIG registers
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every irq_src bit.
module irq_controller #(
    parameter logic [15:0] BASE_ADDR = 16'h1020,
    parameter int          NUM_SRC   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic               interrupt_0,
    output logic               interrupt_1,
    output logic               interrupt_2,
    output logic               interrupt_3,
    input  logic               interrupt_0_clr,
    input  logic               interrupt_1_clr,
    input  logic               interrupt_2_clr,
    input  logic               interrupt_3_clr,
    input  logic [15:0]        io_address,
    input  logic [7:0]         io_din,
    input  logic               io_write_en,
    input  logic               io_read_en,
    output logic [7:0]         io_dout,
    output logic               io_sel
);

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overflow;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_src;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = irq_src;
`endif

    // Offset arithmetic wraps below BASE_ADDR, so one unsigned compare covers both window bounds.
    logic [15:0] offset;
    logic        hit;
    logic        wr_hit;
    logic        rd_hit;
    logic [1:0]  reg_idx;

    assign offset  = io_address - BASE_ADDR;
    assign hit     = (offset < 16'd4);
    assign reg_idx = offset[1:0];
    assign wr_hit  = io_write_en && hit;
    assign rd_hit  = io_read_en && hit;

    logic [NUM_SRC-1:0] ack;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] hw_set;
    logic [NUM_SRC-1:0] sw_set;
    logic [NUM_SRC-1:0] pend_w1c;
    logic [NUM_SRC-1:0] ovf_w1c;
    logic [NUM_SRC-1:0] ovf_event;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] overflow_next;
    logic [7:0]         rd_data;

    assign ack  = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr};
    assign rise = src & ~src_prev;

    always_comb begin
        pend_w1c = '0;
        ovf_w1c  = '0;
        sw_set   = '0;
        if (wr_hit && reg_idx == 2'd0) begin
            pend_w1c = io_din[3:0];
            ovf_w1c  = io_din[7:4];
        end
        if (wr_hit && reg_idx == 2'd3) begin
            sw_set = io_din[3:0];
        end
        // Level sources re-set every cycle they are high, so any clear is ignored until they drop.
        hw_set        = (mode & src) | (~mode & rise);
        ovf_event     = ~mode & rise & pending;
        pending_next  = hw_set | sw_set | (pending & ~(ack | pend_w1c));
        overflow_next = ovf_event | (overflow & ~ovf_w1c);
    end

    always_comb begin
        rd_data = 8'h00;
        case (reg_idx)
            2'd0:    rd_data = {overflow, pending};
            2'd1:    rd_data = {4'h0, mask};
            2'd2:    rd_data = {4'h0, mode};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_prev <= '0;
            pending  <= '0;
            overflow <= '0;
            mask     <= '0;
            mode     <= '0;
            io_dout  <= 8'h00;
            io_sel   <= 1'b0;
        end else begin
            src_prev <= src;
            pending  <= pending_next;
            overflow <= overflow_next;
            if (wr_hit && reg_idx == 2'd1) begin
                mask <= io_din[3:0];
            end
            if (wr_hit && reg_idx == 2'd2) begin
                mode <= io_din[3:0];
            end
            io_sel <= rd_hit;
            if (rd_hit) begin
                io_dout <= rd_data;
            end
        end
    end

    assign interrupt_0 = pending[0] & mask[0];
    assign interrupt_1 = pending[1] & mask[1];
    assign interrupt_2 = pending[2] & mask[2];
    assign interrupt_3 = pending[3] & mask[3];

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller (table, directed and random phases)
module tb_irq_controller;

    localparam logic [15:0] BASE = 16'h1020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  irq_src = 4'h0;
    logic        interrupt_0, interrupt_1, interrupt_2, interrupt_3;
    logic        interrupt_0_clr = 1'b0, interrupt_1_clr = 1'b0;
    logic        interrupt_2_clr = 1'b0, interrupt_3_clr = 1'b0;
    logic [15:0] io_address = 16'h0000;
    logic [7:0]  io_din = 8'h00;
    logic        io_write_en = 1'b0;
    logic        io_read_en = 1'b0;
    logic [7:0]  io_dout;
    logic        io_sel;
    logic [3:0]  ints;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(.BASE_ADDR(BASE), .NUM_SRC(4)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src),
        .interrupt_0(interrupt_0), .interrupt_1(interrupt_1),
        .interrupt_2(interrupt_2), .interrupt_3(interrupt_3),
        .interrupt_0_clr(interrupt_0_clr), .interrupt_1_clr(interrupt_1_clr),
        .interrupt_2_clr(interrupt_2_clr), .interrupt_3_clr(interrupt_3_clr),
        .io_address(io_address), .io_din(io_din),
        .io_write_en(io_write_en), .io_read_en(io_read_en),
        .io_dout(io_dout), .io_sel(io_sel)
    );

    always #5 clk = ~clk;
    assign ints = {interrupt_3, interrupt_2, interrupt_1, interrupt_0};

    // Reference state: one bit per source, updated from the rules source by source.
    bit       m_pend[4], m_ovf[4], m_mask[4], m_mode[4], m_prev[4];
    bit [7:0] m_dout;
    bit       m_sel;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    function automatic bit [7:0] m_reg(input int idx);
        bit [7:0] v = 8'h00;
        for (int n = 0; n < 4; n++) begin
            if (idx == 0) begin
                v[n] = m_pend[n];
                v[n+4] = m_ovf[n];
            end
            if (idx == 1) v[n] = m_mask[n];
            if (idx == 2) v[n] = m_mode[n];
        end
        return v;
    endfunction

    function automatic bit [3:0] m_ints();
        bit [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = m_pend[n] && m_mask[n];
        return v;
    endfunction

    task automatic model_clear();
        for (int n = 0; n < 4; n++) begin
            m_pend[n] = 0; m_ovf[n] = 0; m_mask[n] = 0; m_mode[n] = 0; m_prev[n] = 0;
        end
        m_dout = 8'h00;
        m_sel  = 0;
    endtask

    // Advance one clock: evaluate the model on the settled inputs, then sample #1 after the edge.
    task automatic step();
        bit np[4], no[4], nmask[4], nmode[4], nprev[4];
        bit [3:0] clr;
        bit rising, set, clear;
        int off;
        bit in_win, wr, rd;
        bit [7:0] nd;
        clr    = {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr};
        off    = int'(io_address) - int'(BASE);
        in_win = (off >= 0) && (off <= 3);
        wr     = io_write_en && in_win;
        rd     = io_read_en && in_win;
        nd     = rd ? m_reg(off) : m_dout;
        for (int n = 0; n < 4; n++) begin
            rising = irq_src[n] && !m_prev[n];
            set    = m_mode[n] ? irq_src[n] : rising;
            if (wr && off == 3 && io_din[n]) set = 1;
            clear  = clr[n] || (wr && off == 0 && io_din[n]);
            np[n]  = set ? 1'b1 : (clear ? 1'b0 : m_pend[n]);
            if (!m_mode[n] && rising && m_pend[n]) no[n] = 1;
            else if (wr && off == 0 && io_din[n+4]) no[n] = 0;
            else no[n] = m_ovf[n];
            nmask[n] = (wr && off == 1) ? io_din[n] : m_mask[n];
            nmode[n] = (wr && off == 2) ? io_din[n] : m_mode[n];
            nprev[n] = irq_src[n];
        end
        @(posedge clk);
        #1;
        m_pend = np; m_ovf = no; m_mask = nmask; m_mode = nmode; m_prev = nprev;
        m_dout = nd;
        m_sel  = rd;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        irq_src = 4'h0;
        {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr} = 4'h0;
        io_write_en = 1'b0;
        io_read_en = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        io_address = addr; io_din = data; io_write_en = 1'b1;
        step();
        io_write_en = 1'b0;
    endtask

    task automatic bus_read(input string name, input logic [15:0] addr,
                            input logic exp_sel, input logic [7:0] exp_dout);
        io_address = addr; io_read_en = 1'b1;
        step();
        io_read_en = 1'b0;
        check({name, ".sel"}, {7'h0, io_sel}, {7'h0, exp_sel});
        check({name, ".dout"}, io_dout, exp_dout);
    endtask

    task automatic set_clr(input logic [3:0] v);
        {interrupt_3_clr, interrupt_2_clr, interrupt_1_clr, interrupt_0_clr} = v;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_sel;
        logic [7:0]  exp_dout;
    } bus_vec_t;

    bus_vec_t vecs[16];

    initial begin
        vecs[0]  = '{1'b1, 16'h1021, 8'h5A, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 16'h1021, 8'h00, 1'b1, 8'h0A};
        vecs[2]  = '{1'b1, 16'h1022, 8'hF3, 1'b0, 8'h00};
        vecs[3]  = '{1'b0, 16'h1022, 8'h00, 1'b1, 8'h03};
        vecs[4]  = '{1'b0, 16'h1023, 8'h00, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 16'h1020, 8'h00, 1'b1, 8'h00};
        vecs[6]  = '{1'b1, 16'h1023, 8'h05, 1'b0, 8'h00};
        vecs[7]  = '{1'b0, 16'h1020, 8'h00, 1'b1, 8'h05};
        vecs[8]  = '{1'b1, 16'h1020, 8'h01, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 16'h1020, 8'h00, 1'b1, 8'h04};
        vecs[10] = '{1'b1, 16'h1024, 8'hFF, 1'b0, 8'h00};
        vecs[11] = '{1'b0, 16'h1021, 8'h00, 1'b1, 8'h0A};
        vecs[12] = '{1'b0, 16'h1030, 8'h00, 1'b0, 8'h0A};
        vecs[13] = '{1'b0, 16'h101F, 8'h00, 1'b0, 8'h0A};
        vecs[14] = '{1'b1, 16'h101F, 8'hFF, 1'b0, 8'h00};
        vecs[15] = '{1'b0, 16'h1022, 8'h00, 1'b1, 8'h03};

        repeat (2) @(posedge clk);
        #1;
        check("reset.ints", {4'h0, ints}, 8'h00);
        check("reset.sel", {7'h0, io_sel}, 8'h00);
        check("reset.dout", io_dout, 8'h00);
        do_reset();

        // Register-map table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
            else bus_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_sel, vecs[i].exp_dout);
        end

        // Basic edge capture, ack, readback
        do_reset();
        bus_write(BASE + 16'd1, 8'h01);
        irq_src = 4'h1; step(); irq_src = 4'h0;
        check("edge0.int", {4'h0, ints}, 8'h01);
        set_clr(4'h1); step(); set_clr(4'h0);
        check("ack0.int", {4'h0, ints}, 8'h00);
        bus_read("ack0.status", BASE, 1'b1, 8'h00);

        // Masked source stays pending, unmask asserts at once
        bus_write(BASE + 16'd1, 8'h00);
        irq_src = 4'h4; step(); irq_src = 4'h0;
        check("masked2.int", {4'h0, ints}, 8'h00);
        bus_read("masked2.status", BASE, 1'b1, 8'h04);
        bus_write(BASE + 16'd1, 8'h04);
        check("unmask2.int", {4'h0, ints}, 8'h04);

        // Overflow from two un-acked edges, then partial W1C
        bus_write(BASE, 8'hFF);
        irq_src = 4'h2; step(); irq_src = 4'h0; step();
        irq_src = 4'h2; step(); irq_src = 4'h0; step();
        bus_read("ovf1.status", BASE, 1'b1, 8'h22);
        bus_write(BASE, 8'h20);
        bus_read("ovf1.w1c", BASE, 1'b1, 8'h02);

        // Ack and new edge in the same cycle: set wins, overflow recorded
        bus_write(BASE, 8'hFF);
        irq_src = 4'h8; step(); irq_src = 4'h0; step();
        irq_src = 4'h8; set_clr(4'h8); step(); set_clr(4'h0); irq_src = 4'h0;
        bus_read("race3.status", BASE, 1'b1, 8'h88);
        bus_write(BASE, 8'hFF);

        // Level mode ignores acks while the source is high
        bus_write(BASE + 16'd2, 8'h02);
        bus_write(BASE + 16'd1, 8'h02);
        irq_src = 4'h2; step();
        check("level1.set", {4'h0, ints}, 8'h02);
        for (int i = 0; i < 3; i++) begin
            set_clr(4'h2); step(); set_clr(4'h0);
            check($sformatf("level1.ack%0d", i), {4'h0, ints}, 8'h02);
        end
        irq_src = 4'h0; set_clr(4'h2); step(); set_clr(4'h0);
        check("level1.drop", {4'h0, ints}, 8'h00);
        bus_write(BASE + 16'd3, 8'h08);
        bus_read("swtrig3.status", BASE, 1'b1, 8'h08);
        bus_write(BASE + 16'd2, 8'h00);
        bus_write(BASE, 8'hFF);

        // Read latency, address miss, read-during-write, reset mid-read
        bus_write(BASE + 16'd1, 8'hA5);
        bus_read("rdmask", BASE + 16'd1, 1'b1, 8'h05);
        step();
        check("rdmask.sel_drop", {7'h0, io_sel}, 8'h00);
        bus_read("rdmiss", 16'h1030, 1'b0, 8'h05);
        io_address = BASE + 16'd1; io_din = 8'h0F;
        io_write_en = 1'b1; io_read_en = 1'b1;
        step();
        io_write_en = 1'b0; io_read_en = 1'b0;
        check("rw.old", io_dout, 8'h05);
        bus_read("rw.new", BASE + 16'd1, 1'b1, 8'h0F);
        io_address = BASE; io_read_en = 1'b1;
        step();
        check("midrd.sel_before", {7'h0, io_sel}, 8'h01);
        reset = 1'b0;
        #1;
        check("midrd.sel", {7'h0, io_sel}, 8'h00);
        check("midrd.dout", io_dout, 8'h00);
        check("midrd.ints", {4'h0, ints}, 8'h00);
        do_reset();

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 600; cyc++) begin
            int op;
            if ($urandom_range(0, 2) == 0) irq_src = 4'($urandom_range(0, 15));
            set_clr(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            op = $urandom_range(0, 3);
            io_address  = BASE - 16'd1 + 16'($urandom_range(0, 5));
            io_din      = 8'($urandom_range(0, 255));
            io_read_en  = op[0];
            io_write_en = op[1];
            step();
            check($sformatf("rnd%0d.ints", cyc), {4'h0, ints}, {4'h0, m_ints()});
            check($sformatf("rnd%0d.sel", cyc), {7'h0, io_sel}, {7'h0, m_sel});
            check($sformatf("rnd%0d.dout", cyc), io_dout, m_dout);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
